alu_control_sequencer: RTL and testbench

ALU_CONTROL_SEQUENCER -- requirements
Module: alu_control_sequencer

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/reg_decoder_4to16.sv | 14 +
 rtl/alu_control_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: IR field positions, opcode constants, and the
// control-sequencer state enumeration.
package cpu_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
  localparam logic [4:0] OP_ROL       = 5'b01001;
  localparam logic [4:0] OP_ALU_LAST  = 5'b01011;
  localparam logic [4:0] OP_MUL       = 5'b01111;
  localparam logic [4:0] OP_DIV       = 5'b10000;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_DONE  = 4'd8,
    S_FAULT = 4'd9
  } state_t;

  // Three-register ALU ops occupy one contiguous opcode range.
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  endfunction

  function automatic logic is_muldiv_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_decoder_4to16.sv
// 4-to-16 one-hot decoder for register-file drive/load enables.
module reg_decoder_4to16 (
  input  logic [3:0]  i_field,
  input  logic        i_en,
  output logic [15:0] o_onehot
);

  // Exactly one bit high when enabled, all zero otherwise.
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_field] = 1'b1;
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Fetch/execute control sequencer for a single-bus datapath.
// Optional macro ALU_SEQ_MULDIV_EN adds MUL/DIV with the extra T6 step that
// moves the high product/remainder into HI.
//
// Handshake: start is a request sampled only in IDLE (busy low); done is a
// one-cycle completion pulse; mem_rdy qualifies memory data during T1 only.
module alu_control_sequencer
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        mem_rdy,
  input  logic [31:0] ir_in,
  output logic        PCout,
  output logic        IncPC,
  output logic        MARin,
  output logic        memRead,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output state_t      dbg_state
);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_wait_cnt;
  logic [4:0]  w_op;
  logic [3:0]  w_ra, w_rb, w_rc;
  logic [3:0]  w_rout_sel, w_rin_sel;
  logic        w_rout_en, w_rin_en;
  logic        w_alu, w_muldiv;
  logic        w_unused_ir;

  assign w_op  = ir_in[OP_MSB:OP_LSB];
  assign w_ra  = ir_in[RA_MSB:RA_LSB];
  assign w_rb  = ir_in[RB_MSB:RB_LSB];
  assign w_rc  = ir_in[RC_MSB:RC_LSB];
  assign w_alu = is_alu_op(w_op);
`ifdef ALU_SEQ_MULDIV_EN
  assign w_muldiv = is_muldiv_op(w_op);
`else
  assign w_muldiv = 1'b0;
`endif
  assign w_unused_ir = ^ir_in[14:0];
  assign dbg_state   = r_state;

  // State register; clear aborts any sequence immediately.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Memory wait counter: zeroed on the way into T1, counts idle T1 cycles.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                            r_wait_cnt <= 4'd0;
    else if (r_state == S_T0)             r_wait_cnt <= 4'd0;
    else if (r_state == S_T1 && !mem_rdy) r_wait_cnt <= r_wait_cnt + 4'd1;
  end

  // Next-state and strobe decode; everything defaults low.
  always_comb begin
    w_next_state = r_state;
    PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0; memRead = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
    Zhighout = 1'b0; LOin = 1'b0; HIin = 1'b0;
    alu_op = 5'd0; busy = 1'b1; done = 1'b0; fault = 1'b0;
    w_rout_sel = 4'd0; w_rout_en = 1'b0; w_rin_sel = 4'd0; w_rin_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = S_T0;
      end
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        w_next_state = S_T1;
      end
      S_T1: begin
        memRead = 1'b1; MDRin = 1'b1;
        if (mem_rdy)                  w_next_state = S_T2;
        else if (r_wait_cnt == 4'hF)  w_next_state = S_FAULT;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        w_next_state = S_T3;
      end
      S_T3: begin
        alu_op = w_op;
        if (w_alu) begin
          w_rout_sel = w_rb; w_rout_en = 1'b1; Yin = 1'b1;
          w_next_state = S_T4;
        end else if (w_muldiv) begin
          w_rout_sel = w_ra; w_rout_en = 1'b1; Yin = 1'b1;
          w_next_state = S_T4;
        end else begin
          w_next_state = S_FAULT;
        end
      end
      S_T4: begin
        alu_op = w_op; Zin = 1'b1; w_rout_en = 1'b1;
        w_rout_sel = w_muldiv ? w_rb : w_rc;
        w_next_state = S_T5;
      end
      S_T5: begin
        alu_op = w_op; Zlowout = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
        if (w_muldiv) begin
          LOin = 1'b1;
          w_next_state = S_T6;
        end else begin
          w_rin_sel = w_ra; w_rin_en = 1'b1;
          w_next_state = S_DONE;
        end
`else
        w_rin_sel = w_ra; w_rin_en = 1'b1;
        w_next_state = S_DONE;
`endif
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_T6: begin
        alu_op = w_op; Zhighout = 1'b1; HIin = 1'b1;
        w_next_state = S_DONE;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        w_next_state = S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        busy = 1'b0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  reg_decoder_4to16 u_rout_dec (
    .i_field  (w_rout_sel),
    .i_en     (w_rout_en),
    .o_onehot (Rout)
  );

  reg_decoder_4to16 u_rin_dec (
    .i_field  (w_rin_sel),
    .i_en     (w_rin_en),
    .o_onehot (Rin)
  );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Self-checking bench for alu_control_sequencer: the driver pushes the
// expected per-cycle output vector for every cycle it drives, and a monitor
// on the falling edge pops and compares.
module tb_alu_control_sequencer;

  localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T2 = 3, P_T3 = 4,
                 P_T4 = 5, P_T5 = 6, P_T6 = 7, P_DONE = 8, P_FAULT = 9;
  localparam int W = 53;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        mem_rdy = 1'b0;
  logic [31:0] ir_in = 32'd0;
  logic PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, LOin, HIin, busy, done, fault;
  logic [15:0] Rout, Rin;
  logic [4:0]  alu_op;
  cpu_pkg::state_t dbg_state;
  logic [W-1:0] w_got;
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  alu_control_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .mem_rdy(mem_rdy), .ir_in(ir_in),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .memRead(memRead), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin), .Rout(Rout), .Rin(Rin),
    .alu_op(alu_op), .busy(busy), .done(done), .fault(fault), .dbg_state(dbg_state)
  );

  assign w_got = {PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin,
                  Zlowout, Zhighout, LOin, HIin, Rout, Rin, alu_op, busy, done, fault};

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) n_cyc <= n_cyc + 1;

  function automatic bit md_enabled();
`ifdef ALU_SEQ_MULDIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit op_alu(input logic [4:0] op);
    return (op >= 5'd3) && (op <= 5'd11);
  endfunction

  function automatic bit op_md(input logic [4:0] op);
    return md_enabled() && (op == 5'd15 || op == 5'd16);
  endfunction

  // Reference: what every output should be in a given step of the sequence.
  function automatic logic [W-1:0] ev(input int ph, input logic [31:0] ir);
    logic [12:0] s;
    logic [15:0] ro, ri;
    logic [4:0]  op, ao;
    logic        b, d, f;
    bit          alu, md;
    op = ir[31:27];
    alu = op_alu(op);
    md  = op_md(op);
    s = '0; ro = '0; ri = '0; ao = '0; d = 1'b0; f = 1'b0;
    b = (ph != P_IDLE);
    if (ph >= P_T3 && ph <= P_T6) ao = op;
    case (ph)
      P_T0: s[12:10] = 3'b111;
      P_T1: s[9:8] = 2'b11;
      P_T2: s[7:6] = 2'b11;
      P_T3: begin
        if (alu)     begin ro = 16'h1 << ir[22:19]; s[5] = 1'b1; end
        else if (md) begin ro = 16'h1 << ir[26:23]; s[5] = 1'b1; end
      end
      P_T4: begin s[4] = 1'b1; ro = md ? (16'h1 << ir[22:19]) : (16'h1 << ir[18:15]); end
      P_T5: begin s[3] = 1'b1; if (md) s[1] = 1'b1; else ri = 16'h1 << ir[26:23]; end
      P_T6: begin s[2] = 1'b1; s[0] = 1'b1; end
      P_DONE:  d = 1'b1;
      P_FAULT: f = 1'b1;
      default: ;
    endcase
    return {s, ro, ri, ao, b, d, f};
  endfunction

  // Driver: one cycle of inputs plus its expected outputs.
  task automatic cyc(input logic s, input logic rdy, input logic clr,
                     input logic [31:0] ir, input int ph);
    @(posedge clock);
    #1;
    start = s; mem_rdy = rdy; clear = clr; ir_in = ir;
    exp_q.push_back(ev(ph, ir));
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Fault is sticky: hold a few cycles with noise on start, then clear.
  task automatic fault_then_clear(input logic [31:0] ir);
    repeat (3) cyc(rbit(), rbit(), 1'b0, ir, P_FAULT);
    cyc(1'b0, 1'b0, 1'b1, ir, P_IDLE);
    cyc(1'b0, 1'b0, 1'b0, ir, P_IDLE);
  endtask

  // One full sequence: delay = T1 cycles with mem_rdy low; abort = clear in T4.
  task automatic run_seq(input logic [31:0] ir, input int delay, input bit abort);
    logic [4:0] op;
    op = ir[31:27];
    cyc(1'b1, rbit(), 1'b0, ir, P_IDLE);
    cyc(rbit(), rbit(), 1'b0, ir, P_T0);
    for (int i = 0; i < ((delay < 16) ? delay : 16); i++)
      cyc(rbit(), 1'b0, 1'b0, ir, P_T1);
    if (delay >= 16) begin
      fault_then_clear(ir);
      return;
    end
    cyc(rbit(), 1'b1, 1'b0, ir, P_T1);
    cyc(rbit(), rbit(), 1'b0, ir, P_T2);
    cyc(rbit(), rbit(), 1'b0, ir, P_T3);
    if (!(op_alu(op) || op_md(op))) begin
      fault_then_clear(ir);
      return;
    end
    if (abort) begin
      cyc(1'b0, rbit(), 1'b1, ir, P_IDLE);
      cyc(1'b0, rbit(), 1'b0, ir, P_IDLE);
      return;
    end
    cyc(rbit(), rbit(), 1'b0, ir, P_T4);
    cyc(rbit(), rbit(), 1'b0, ir, P_T5);
    if (op_md(op)) cyc(rbit(), rbit(), 1'b0, ir, P_T6);
    cyc(rbit(), rbit(), 1'b0, ir, P_DONE);
    cyc(1'b0, rbit(), 1'b0, ir, P_IDLE);
  endtask

  // Scoreboard monitor: compare on the falling edge, away from the active edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (w_got !== e) begin
          n_fail++;
          $display("FAIL outputs cycle=%0d got=%h exp=%h", n_cyc, w_got, e);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] ir;
    logic [4:0]  op;
    int          k, delay;
    // Reset held, then released; outputs must read all-zero throughout.
    cyc(1'b1, 1'b1, 1'b1, 32'h4891_8000, P_IDLE);
    cyc(1'b0, 1'b0, 1'b1, 32'h4891_8000, P_IDLE);
    cyc(1'b0, 1'b0, 1'b0, 32'h4891_8000, P_IDLE);

    run_seq(32'h4891_8000, 0, 1'b0);   // ROL, done in 7th cycle
    run_seq(32'h4891_8000, 3, 1'b0);   // memory wait, done in 10th cycle
    run_seq(32'h4891_8000, 15, 1'b0);  // last cycle before timeout
    run_seq(32'h4891_8000, 16, 1'b0);  // timeout
    run_seq(32'hF800_0000, 0, 1'b0);   // illegal opcode
    run_seq(32'h4891_8000, 1, 1'b1);   // clear during T4
    run_seq(32'h4891_8000, 0, 1'b0);   // normal after abort
    run_seq(32'h7891_0000, 0, 1'b0);   // MUL R1,R2
    run_seq(32'h8123_4000, 2, 1'b0);   // DIV

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 3);
      if (k <= 1) op = 5'($urandom_range(3, 11));
      else if (k == 2) op = ($urandom_range(0, 1) != 0) ? 5'd15 : 5'd16;
      else begin
        op = 5'($urandom_range(0, 31));
        while (op_alu(op)) op = 5'($urandom_range(0, 31));
      end
      ir = {op, 27'($urandom())};
      k = $urandom_range(0, 9);
      if (k < 6)       delay = $urandom_range(0, 4);
      else if (k < 8)  delay = $urandom_range(10, 15);
      else if (k == 8) delay = 16;
      else             delay = 0;
      run_seq(ir, delay, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) cyc(1'b0, rbit(), 1'b0, ir, P_IDLE);
    end

    @(posedge clock);
    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
